// File: rtl/xc_malu_seq.sv
// -----------------------------------------------------------------------------
// xc_malu_seq
// Iteration sequencer and state-register stage for the multi-cycle
// mul/div/rem/pmul datapath. It owns the count/acc/arg registers the datapath
// reads each cycle, writes back the datapath's next-state values every
// iteration, captures the 64-bit result on step_ready (or an error result when
// the iteration limit is reached), and offers it downstream under valid/ready.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   flush                 abort any operation (highest priority after reset)
//   valid / in_ready      issue handshake
//   ld_acc, ld_arg_0/1    initial register values loaded on issue
//   count, acc, arg_0/1   current state, to datapath
//   n_acc, n_arg_0/1      next state, from datapath
//   step_ready/result     datapath completion and its result
//   busy                  an operation is iterating
//   out_valid/out_ready   result handshake; result/error held until accepted
// -----------------------------------------------------------------------------
module xc_malu_seq #(
    parameter int CW        = 6,
    parameter int MAX_COUNT = 40
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          valid,
    output logic          in_ready,
    input  logic [63:0]   ld_acc,
    input  logic [31:0]   ld_arg_0,
    input  logic [31:0]   ld_arg_1,
    output logic [CW-1:0] count,
    output logic [63:0]   acc,
    output logic [31:0]   arg_0,
    output logic [31:0]   arg_1,
    input  logic [63:0]   n_acc,
    input  logic [31:0]   n_arg_0,
    input  logic [31:0]   n_arg_1,
    input  logic          step_ready,
    input  logic [63:0]   step_result,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   result,
    output logic          error
);

    localparam logic [CW-1:0] LAST_COUNT = CW'(MAX_COUNT);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t state_r;
    logic   issue_s;

    // Issue acceptance: idle, or done with the current result being taken
    // this same cycle (back-to-back). A flush blocks any issue.
    always_comb begin
        in_ready = 1'b0;
        if (flush) begin
            in_ready = 1'b0;
        end else if (state_r == ST_IDLE) begin
            in_ready = 1'b1;
        end else if (state_r == ST_DONE) begin
            in_ready = out_ready;
        end else begin
            in_ready = 1'b0;
        end
    end

    assign issue_s = valid && in_ready;
    assign busy    = (state_r == ST_RUN);

    // Sequencer state, datapath state registers and the result holding stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            count     <= '0;
            acc       <= 64'd0;
            arg_0     <= 32'd0;
            arg_1     <= 32'd0;
            result    <= 64'd0;
            out_valid <= 1'b0;
            error     <= 1'b0;
        end else if (flush) begin
            // Result is deliberately kept; only reset clears it.
            state_r   <= ST_IDLE;
            count     <= '0;
            acc       <= 64'd0;
            arg_0     <= 32'd0;
            arg_1     <= 32'd0;
            out_valid <= 1'b0;
            error     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (issue_s) begin
                        acc     <= ld_acc;
                        arg_0   <= ld_arg_0;
                        arg_1   <= ld_arg_1;
                        count   <= '0;
                        error   <= 1'b0;
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (step_ready) begin
                        // Final iteration: datapath next-state values are dropped.
                        result    <= step_result;
                        error     <= 1'b0;
                        out_valid <= 1'b1;
                        state_r   <= ST_DONE;
                    end else if (count == LAST_COUNT) begin
                        result    <= 64'd0;
                        error     <= 1'b1;
                        out_valid <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        acc     <= n_acc;
                        arg_0   <= n_arg_0;
                        arg_1   <= n_arg_1;
                        count   <= count + COUNT_ONE;
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (issue_s) begin
                            acc     <= ld_acc;
                            arg_0   <= ld_arg_0;
                            arg_1   <= ld_arg_1;
                            count   <= '0;
                            error   <= 1'b0;
                            state_r <= ST_RUN;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    out_valid <= 1'b0;
                    error     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xc_malu_seq.sv
// -----------------------------------------------------------------------------
// tb_xc_malu_seq
// Self-checking bench for xc_malu_seq. An operation-level model tracks the
// current phase, the iteration index k and the operand bases; the datapath
// registers are predicted in closed form (base + k*increment). Directed
// sequences pin the model with hand-computed literals, then a randomized run
// is compared every cycle.
// -----------------------------------------------------------------------------
module tb_xc_malu_seq;

    localparam int CW   = 6;
    localparam int MAXC = 40;

    logic          clock;
    logic          reset;
    logic          flush;
    logic          valid;
    logic          in_ready;
    logic [63:0]   ld_acc;
    logic [31:0]   ld_arg_0;
    logic [31:0]   ld_arg_1;
    logic [CW-1:0] count;
    logic [63:0]   acc;
    logic [31:0]   arg_0;
    logic [31:0]   arg_1;
    logic [63:0]   n_acc;
    logic [31:0]   n_arg_0;
    logic [31:0]   n_arg_1;
    logic          step_ready;
    logic [63:0]   step_result;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   result;
    logic          error;

    xc_malu_seq #(.CW(CW), .MAX_COUNT(MAXC)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .valid       (valid),
        .in_ready    (in_ready),
        .ld_acc      (ld_acc),
        .ld_arg_0    (ld_arg_0),
        .ld_arg_1    (ld_arg_1),
        .count       (count),
        .acc         (acc),
        .arg_0       (arg_0),
        .arg_1       (arg_1),
        .n_acc       (n_acc),
        .n_arg_0     (n_arg_0),
        .n_arg_1     (n_arg_1),
        .step_ready  (step_ready),
        .step_result (step_result),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .error       (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase 0 = idle, 1 = iterating, 2 = result waiting.
    int            ph;
    int            k;
    int            tk;
    int            tk_next;
    logic [63:0]   base_acc, inc_acc, e_acc, e_result;
    logic [31:0]   base0, base1, inc0, dec1, e_a0, e_a1;
    logic [CW-1:0] e_count;
    logic          e_ov, e_err;
    logic          fixed_mode;
    logic [63:0]   fixed_res;
    bit            chk_en;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic zero_regs();
        k = 0; e_count = '0; e_acc = 64'd0; e_a0 = 32'd0; e_a1 = 32'd0;
    endtask

    task automatic load();
        base_acc = ld_acc; base0 = ld_arg_0; base1 = ld_arg_1;
        k = 0; tk = tk_next; e_count = '0;
        e_acc = ld_acc; e_a0 = ld_arg_0; e_a1 = ld_arg_1;
        e_err = 1'b0; e_ov = 1'b0; ph = 1;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_update();
        logic iss;
        iss = valid && !flush && (ph == 0 || (ph == 2 && out_ready));
        if (reset) begin
            ph = 0; zero_regs(); e_result = 64'd0; e_ov = 1'b0; e_err = 1'b0;
        end else if (flush) begin
            ph = 0; zero_regs(); e_ov = 1'b0; e_err = 1'b0;
        end else if (ph == 0) begin
            if (iss) load();
        end else if (ph == 1) begin
            if (step_ready) begin
                e_result = step_result; e_err = 1'b0; e_ov = 1'b1; ph = 2;
            end else if (k == MAXC) begin
                e_result = 64'd0; e_err = 1'b1; e_ov = 1'b1; ph = 2;
            end else begin
                k++;
                e_count = CW'(k);
                e_acc   = base_acc + 64'(k) * inc_acc;
                e_a0    = base0 + 32'(k) * inc0;
                e_a1    = base1 - 32'(k) * dec1;
            end
        end else begin
            if (out_ready) begin
                e_ov = 1'b0;
                if (iss) load();
                else ph = 0;
            end
        end
    endtask

    // Datapath stand-in: linear next-state and completion at iteration tk.
    task automatic drive_dp();
        n_acc   = e_acc + inc_acc;
        n_arg_0 = e_a0 + inc0;
        n_arg_1 = e_a1 - dec1;
        if (fixed_mode) begin
            step_ready  = (ph == 1 && k == tk);
            step_result = fixed_res;
        end else begin
            step_ready  = (ph == 1 && k == tk) || (ph != 1 && $urandom_range(0, 3) == 0);
            step_result = {$urandom, $urandom};
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        drive_dp();
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("in_ready",  in_ready,  ((ph == 0 || (ph == 2 && out_ready)) && !flush));
            chk("busy",      busy,      (ph == 1));
            chk("out_valid", out_valid, e_ov);
            chk("error",     error,     e_err);
            chk("result",    result,    e_result);
            chk("count",     count,     e_count);
            chk("acc",       acc,       e_acc);
            chk("arg_0",     arg_0,     e_a0);
            chk("arg_1",     arg_1,     e_a1);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        chk_en = 1'b0;
        reset = 1'b1; flush = 1'b0; valid = 1'b0; out_ready = 1'b0;
        ld_acc = 64'd0; ld_arg_0 = 32'd0; ld_arg_1 = 32'd0;
        inc_acc = 64'd1; inc0 = 32'd3; dec1 = 32'd1;
        fixed_mode = 1'b1; fixed_res = 64'h23; tk_next = 99; tk = 99;
        ph = 0; zero_regs(); e_result = 64'd0; e_ov = 1'b0; e_err = 1'b0;
        drive_dp();

        // Reset state
        step(); step();
        reset = 1'b0; chk_en = 1'b1; #1;
        chk("rst_out_valid", out_valid, 64'd0);
        chk("rst_result",    result,    64'd0);
        chk("rst_busy",      busy,      64'd0);
        chk("rst_in_ready",  in_ready,  64'd1);
        chk("rst_count",     count,     64'd0);

        // Basic run: completes at count 3, result 0x23
        ld_acc = 64'd0; ld_arg_0 = 32'h5; ld_arg_1 = 32'h7; tk_next = 3; valid = 1'b1;
        step(); valid = 1'b0; #1;
        chk("basic_count0", count, 64'd0);
        chk("basic_busy",   busy,  64'd1);
        chk("basic_arg0",   arg_0, 64'h5);
        chk("basic_arg1",   arg_1, 64'h7);
        step(); #1; chk("basic_count1", count, 64'd1); chk("basic_acc1", acc, 64'd1);
        step(); #1; chk("basic_count2", count, 64'd2);
        step(); #1; chk("basic_count3", count, 64'd3); chk("basic_acc3", acc, 64'd3);
        chk("basic_arg0_3", arg_0, 64'hE);
        step(); #1;
        chk("basic_out_valid", out_valid, 64'd1);
        chk("basic_result",    result,    64'h23);
        chk("basic_error",     error,     64'd0);

        // Back-pressure: held for 4 cycles, then released
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            chk("bp_out_valid", out_valid, 64'd1);
            chk("bp_result",    result,    64'h23);
            chk("bp_in_ready",  in_ready,  64'd0);
        end
        out_ready = 1'b1; #1;
        chk("bp_release_in_ready", in_ready, 64'd1);
        step(); out_ready = 1'b0; #1;
        chk("bp_idle_busy",      busy,      64'd0);
        chk("bp_idle_out_valid", out_valid, 64'd0);

        // Back-to-back issue in the DONE cycle
        ld_arg_0 = 32'h11; tk_next = 0; valid = 1'b1;
        step(); valid = 1'b0;
        step(); #1;
        chk("b2b_first_done", out_valid, 64'd1);
        out_ready = 1'b1; valid = 1'b1; ld_arg_0 = 32'hAA; tk_next = 2; #1;
        chk("b2b_in_ready", in_ready, 64'd1);
        step(); valid = 1'b0; #1;
        chk("b2b_out_valid", out_valid, 64'd0);
        chk("b2b_busy",      busy,      64'd1);
        chk("b2b_arg0",      arg_0,     64'hAA);
        chk("b2b_count",     count,     64'd0);
        step(); step(); step(); #1;
        chk("b2b_second_done", out_valid, 64'd1);
        step(); #1;
        chk("b2b_idle", busy, 64'd0);

        // Timeout: no step_ready, 42 cycles from issue to out_valid
        out_ready = 1'b0; tk_next = 99; ld_acc = 64'h1234; valid = 1'b1;
        step(); valid = 1'b0;
        for (int i = 0; i < 40; i++) step();
        #1;
        chk("to_count40", count, 64'd40);
        chk("to_busy",    busy,  64'd1);
        step(); #1;
        chk("to_out_valid", out_valid, 64'd1);
        chk("to_error",     error,     64'd1);
        chk("to_result",    result,    64'd0);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // Flush mid-run, then flush colliding with an issue
        tk_next = 99; valid = 1'b1;
        step(); valid = 1'b0;
        step(); step(); #1;
        chk("fl_count2", count, 64'd2);
        flush = 1'b1; #1;
        chk("fl_in_ready", in_ready, 64'd0);
        step(); flush = 1'b0; #1;
        chk("fl_busy",      busy,      64'd0);
        chk("fl_count",     count,     64'd0);
        chk("fl_out_valid", out_valid, 64'd0);
        chk("fl_acc",       acc,       64'd0);
        valid = 1'b1; flush = 1'b1;
        step(); valid = 1'b0; flush = 1'b0; #1;
        chk("fl_drop_busy",  busy,  64'd0);
        chk("fl_drop_count", count, 64'd0);

        // Reset while a result is waiting
        tk_next = 0; valid = 1'b1;
        step(); valid = 1'b0;
        step(); #1;
        chk("rd_out_valid_pre", out_valid, 64'd1);
        chk("rd_result_pre",    result,    64'h23);
        reset = 1'b1;
        step(); reset = 1'b0; #1;
        chk("rd_out_valid", out_valid, 64'd0);
        chk("rd_result",    result,    64'd0);
        chk("rd_in_ready",  in_ready,  64'd1);

        // Randomized run
        fixed_mode = 1'b0;
        inc_acc = {$urandom, $urandom}; inc0 = $urandom; dec1 = $urandom;
        for (int i = 0; i < 4000; i++) begin
            step();
            reset     = ($urandom_range(0, 499) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            valid     = $urandom_range(0, 1) == 1;
            out_ready = ($urandom_range(0, 9) < 6);
            ld_acc    = {$urandom, $urandom};
            ld_arg_0  = $urandom;
            ld_arg_1  = $urandom;
            tk_next   = $urandom_range(0, 45);
        end
        reset = 1'b0; flush = 1'b0; valid = 1'b0;
        step(); step(); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
